// File: rtl/mlp1_pkg.sv
// Shared constants and lane helpers for the mlp1 reduce/ReLU tile.
package mlp1_pkg;

  localparam int unsigned LANES = 4;
  // Widest lane the helpers support; the top slices results down to its own lane width.
  localparam int unsigned MaxLaneW = 32;

  // Low bit index of lane idx in a word made of lw-bit lanes.
  function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned lw);
    return idx * lw;
  endfunction

  // Clamp a sign-extended sum to the positive lw-bit signed range; negatives become 0.
  function automatic logic [MaxLaneW-1:0] sat_relu(input logic signed [MaxLaneW+1:0] sum,
                                                   input int unsigned lw);
    logic [MaxLaneW+1:0] max_pos;
    max_pos = ((MaxLaneW+2)'(1) << (lw - 1)) - (MaxLaneW+2)'(1);
    if (sum[MaxLaneW+1]) begin
      return '0;
    end else if (sum > $signed(max_pos)) begin
      return max_pos[MaxLaneW-1:0];
    end else begin
      return sum[MaxLaneW-1:0];
    end
  endfunction

endpackage

// File: rtl/mlp1_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; rdata reads 0 when empty.
module mlp1_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  logic [Width-1:0] wdata,
  output logic             full,
  input  logic             ren,
  output logic [Width-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_wptr == r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push = wen & ~full;
  assign w_pop  = ren & ~empty;
  assign rdata  = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible through a non-empty head.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mlp1.sv
// MLP tile: four input FIFOs, lane-wise reduce + saturating ReLU stage, one output FIFO.
module mlp1
  import mlp1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dispatcher0_ififo_wdata,
  input  logic                  dispatcher0_ififo_wen,
  output logic                  dispatcher0_ififo_rdy,
  input  logic [DATA_WIDTH-1:0] dispatcher1_ififo_wdata,
  input  logic                  dispatcher1_ififo_wen,
  output logic                  dispatcher1_ififo_rdy,
  input  logic [DATA_WIDTH-1:0] dispatcher2_ififo_wdata,
  input  logic                  dispatcher2_ififo_wen,
  output logic                  dispatcher2_ififo_rdy,
  input  logic [DATA_WIDTH-1:0] dispatcher3_ififo_wdata,
  input  logic                  dispatcher3_ififo_wen,
  output logic                  dispatcher3_ififo_rdy,
  output logic [DATA_WIDTH-1:0] collector_ofifo_rdata,
  input  logic                  collector_ofifo_ren,
  output logic                  collector_ofifo_rdy
);

  localparam int unsigned L    = DATA_WIDTH / LANES;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] w_in_wdata [LANES];
  logic [DATA_WIDTH-1:0] w_in_rdata [LANES];
  logic [LANES-1:0]      w_port_wen;
  logic [LANES-1:0]      w_in_wen;
  logic [LANES-1:0]      w_in_full;
  logic [LANES-1:0]      w_in_empty;
  logic [LANES-1:0]      w_rdy;
  logic                  w_fire;
  logic                  w_pop;
  logic                  w_out_full;
  logic                  w_out_empty;
  logic                  w_out_wen;
  logic [DATA_WIDTH-1:0] w_result;
  logic signed [L+1:0]   w_sum;
  logic [MaxLaneW-1:0]   w_sat;

  logic                  r_live;     // high from the first edge after reset release
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic [CntW-1:0]       r_claimed;  // output slots held by the stage register plus the FIFO

  assign w_in_wdata[0] = dispatcher0_ififo_wdata;
  assign w_in_wdata[1] = dispatcher1_ififo_wdata;
  assign w_in_wdata[2] = dispatcher2_ififo_wdata;
  assign w_in_wdata[3] = dispatcher3_ififo_wdata;
  assign w_port_wen    = {dispatcher3_ififo_wen, dispatcher2_ififo_wen,
                          dispatcher1_ififo_wen, dispatcher0_ififo_wen};

  assign w_rdy    = ~w_in_full & {LANES{r_live}};
  assign w_in_wen = w_port_wen & w_rdy;

  assign dispatcher0_ififo_rdy = w_rdy[0];
  assign dispatcher1_ififo_rdy = w_rdy[1];
  assign dispatcher2_ififo_rdy = w_rdy[2];
  assign dispatcher3_ififo_rdy = w_rdy[3];

  assign w_fire = ~(|w_in_empty) && (r_claimed < CntW'(FIFO_DEPTH));
  assign w_pop  = collector_ofifo_ren & ~w_out_empty;
  // Claim accounting already guarantees room; the full gate is only a backstop.
  assign w_out_wen = r_valid & ~w_out_full;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_in
    mlp1_fifo #(
      .Width(DATA_WIDTH),
      .Depth(FIFO_DEPTH)
    ) u_ififo (
      .clk  (clk),
      .reset(reset),
      .wen  (w_in_wen[gi]),
      .wdata(w_in_wdata[gi]),
      .full (w_in_full[gi]),
      .ren  (w_fire),
      .rdata(w_in_rdata[gi]),
      .empty(w_in_empty[gi])
    );
  end

  // Result lane n is the saturated, rectified sum of the four lanes of dispatcher n.
  always_comb begin
    w_result = '0;
    w_sum    = '0;
    w_sat    = '0;
    for (int n = 0; n < LANES; n++) begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) begin
        w_sum = w_sum + (L+2)'($signed(w_in_rdata[n][lane_lo(i, L) +: L]));
      end
      w_sat = sat_relu((MaxLaneW+2)'(w_sum), L);
      w_result[lane_lo(n, L) +: L] = w_sat[L-1:0];
    end
  end

  // Stage register, slot-claim counter and post-reset ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_live    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_claimed <= '0;
    end else begin
      r_live  <= 1'b1;
      r_valid <= w_fire;
      if (w_fire) r_result <= w_result;
      unique case ({w_fire, w_pop})
        2'b10:   r_claimed <= r_claimed + CntW'(1);
        2'b01:   r_claimed <= r_claimed - CntW'(1);
        default: r_claimed <= r_claimed;
      endcase
    end
  end

  mlp1_fifo #(
    .Width(DATA_WIDTH),
    .Depth(FIFO_DEPTH)
  ) u_ofifo (
    .clk  (clk),
    .reset(reset),
    .wen  (w_out_wen),
    .wdata(r_result),
    .full (w_out_full),
    .ren  (collector_ofifo_ren),
    .rdata(collector_ofifo_rdata),
    .empty(w_out_empty)
  );

  assign collector_ofifo_rdy = ~w_out_empty;

endmodule

// File: tb/tb_mlp1.sv
// Self-checking bench for mlp1: constant vectors, back-pressure, streaming, reset, random traffic.
module tb_mlp1;

  localparam int DW    = 64;
  localparam int L     = 16;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] w [4];
    logic [DW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] wd [4];
  logic [3:0]    wen;
  wire  [3:0]    rdy;
  logic          ren;
  wire  [DW-1:0] rdata;
  wire           crdy;

  logic [DW-1:0] stim [4];
  logic [DW-1:0] q_in [4][$];
  logic [DW-1:0] q_exp [$];
  vec_t          tbl [3];
  int            n_checks = 0;
  int            n_err    = 0;
  int            pops     = 0;

  always #5 clk = ~clk;

  mlp1 #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .dispatcher0_ififo_wdata(wd[0]),
    .dispatcher0_ififo_wen  (wen[0]),
    .dispatcher0_ififo_rdy  (rdy[0]),
    .dispatcher1_ififo_wdata(wd[1]),
    .dispatcher1_ififo_wen  (wen[1]),
    .dispatcher1_ififo_rdy  (rdy[1]),
    .dispatcher2_ififo_wdata(wd[2]),
    .dispatcher2_ififo_wen  (wen[2]),
    .dispatcher2_ififo_rdy  (rdy[2]),
    .dispatcher3_ififo_wdata(wd[3]),
    .dispatcher3_ififo_wen  (wen[3]),
    .dispatcher3_ififo_rdy  (rdy[3]),
    .collector_ofifo_rdata  (rdata),
    .collector_ofifo_ren    (ren),
    .collector_ofifo_rdy    (crdy)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer sum per dispatcher, clamp to lane max, negatives to zero.
  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] ws [4];
    logic [DW-1:0] r;
    logic [L-1:0]  lane;
    int            s;
    ws = '{w0, w1, w2, w3};
    r  = '0;
    for (int n = 0; n < 4; n++) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        lane = ws[n][i*L +: L];
        s += int'($signed(lane));
      end
      if (s > (1 << (L - 1)) - 1) s = (1 << (L - 1)) - 1;
      if (s < 0) s = 0;
      r[n*L +: L] = s[L-1:0];
    end
    return r;
  endfunction

  function automatic void model_pair();
    while (q_in[0].size() > 0 && q_in[1].size() > 0 && q_in[2].size() > 0 &&
           q_in[3].size() > 0) begin
      q_exp.push_back(ref_result(q_in[0].pop_front(), q_in[1].pop_front(),
                                 q_in[2].pop_front(), q_in[3].pop_front()));
    end
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < 4; d++) q_in[d].delete();
    q_exp.delete();
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    logic [L-1:0]  lv;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       lv = 16'h7FFF;
        1:       lv = 16'h8000;
        2:       lv = L'($urandom_range(0, 400)) - 16'd200;
        default: lv = L'($urandom);
      endcase
      w[i*L +: L] = lv;
    end
    return w;
  endfunction

  // One cycle: apply writes/pop, score any pop against the model, advance to edge + 1.
  task automatic drive(input logic [3:0] m, input logic r);
    for (int d = 0; d < 4; d++) begin
      wen[d] = m[d];
      wd[d]  = stim[d];
      if (m[d] && rdy[d]) q_in[d].push_back(stim[d]);
    end
    ren = r;
    if (r && crdy) begin
      pops++;
      if (q_exp.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected no word", rdata);
      end else begin
        chk("result", rdata, q_exp.pop_front());
      end
    end
    model_pair();
    @(posedge clk);
    #1;
    wen = '0;
    ren = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (q_exp.size() == 0 && !crdy) begin
        done = 1'b1;
        break;
      end
      drive(4'b0000, 1'b1);
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got %0d words outstanding expected 0", nm, q_exp.size());
    end
    // Trailing pops catch any word the model does not expect.
    repeat (5) drive(4'b0000, 1'b1);
    chk({nm, "_left"}, DW'(q_exp.size()), '0);
  endtask

  task automatic rand_stim();
    for (int d = 0; d < 4; d++) stim[d] = rand_word();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int drops;

    tbl[0].w   = '{64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001,
                   64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001};
    tbl[0].exp = 64'h000A_000A_000A_000A;
    tbl[1].w   = '{64'h0001_0001_0001_FFFB, 64'h7FFF_7FFF_7FFF_7FFF,
                   64'h8000_8000_8000_8000, 64'h0000_0000_FFCE_0064};
    tbl[1].exp = 64'h0032_0000_7FFF_0000;
    tbl[2].w   = '{64'h0000_0000_4000_4000, 64'h0000_0000_0001_7FFF,
                   64'h0003_FFFF_FFFF_FFFF, 64'h0000_0000_0000_1234};
    tbl[2].exp = 64'h1234_0000_7FFF_7FFF;

    reset = 1'b0;
    wen   = '0;
    ren   = 1'b0;
    for (int d = 0; d < 4; d++) begin
      wd[d]   = '0;
      stim[d] = '0;
    end

    // Reset state and release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", DW'(rdy), '0);
    chk("rst_crdy", DW'(crdy), '0);
    chk("rst_rdata", rdata, '0);
    reset = 1'b1;
    #1;
    chk("release_rdy_before_edge", DW'(rdy), '0);
    tick();
    chk("release_rdy", DW'(rdy), DW'(4'hF));
    chk("release_crdy", DW'(crdy), '0);
    chk("release_rdata", rdata, '0);

    // Constant vectors with exact latency.
    for (int v = 0; v < 3; v++) begin
      stim = tbl[v].w;
      drive(4'hF, 1'b0);
      chk("vec_crdy_e0", DW'(crdy), '0);
      tick();
      chk("vec_crdy_e1", DW'(crdy), '0);
      tick();
      chk("vec_crdy_e2", DW'(crdy), 1);
      chk("vec_rdata", rdata, tbl[v].exp);
      drive(4'b0000, 1'b1);
      chk("vec_crdy_after_pop", DW'(crdy), '0);
      chk("vec_rdata_after_pop", rdata, '0);
    end

    // Back-pressure: fill dispatcher0 alone.
    for (int i = 0; i < DEPTH; i++) begin
      rand_stim();
      drive(4'b0001, 1'b0);
    end
    chk("bp_rdy0_full", DW'(rdy[0]), '0);
    rand_stim();
    drive(4'b0001, 1'b0);
    repeat (3) drive(4'b0000, 1'b0);
    chk("bp_no_output", DW'(crdy), '0);
    for (int i = 0; i < DEPTH; i++) begin
      rand_stim();
      drive(4'b1110, 1'b0);
    end
    repeat (4) drive(4'b0000, 1'b0);
    chk("bp_out_ready", DW'(crdy), 1);
    chk("bp_rdy0_drained", DW'(rdy[0]), 1);
    chk("bp_model_count", DW'(q_exp.size()), DW'(DEPTH));
    // Output FIFO full of claims: new inputs must not fire.
    for (int i = 0; i < DEPTH; i++) begin
      rand_stim();
      drive((i < 2) ? 4'b1111 : 4'b0001, 1'b0);
    end
    repeat (4) drive(4'b0000, 1'b0);
    chk("bp_stalled_rdy0", DW'(rdy[0]), '0);
    drive(4'b0000, 1'b1);
    repeat (4) drive(4'b0000, 1'b0);
    chk("bp_one_fire_rdy0", DW'(rdy[0]), 1);
    rand_stim();
    drive(4'b0001, 1'b0);
    chk("bp_exactly_one_fire", DW'(rdy[0]), '0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      rand_stim();
      drive(4'b1110, 1'b0);
    end
    drain("bp_drain");

    // Streaming: every port writes every cycle, collector always pops.
    p0    = pops;
    drops = 0;
    for (int i = 0; i < 100; i++) begin
      if (rdy !== 4'hF) drops++;
      rand_stim();
      drive(4'hF, 1'b1);
    end
    chk("stream_rdy_drops", DW'(drops), '0);
    chk("stream_throughput", DW'(pops - p0), DW'(97));
    drain("stream_drain");

    // Reset mid-stream with words queued.
    for (int i = 0; i < 3; i++) begin
      rand_stim();
      drive(4'hF, 1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_rdy", DW'(rdy), '0);
    chk("midrst_crdy", DW'(crdy), '0);
    chk("midrst_rdata", rdata, '0);
    model_clear();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("midrst_release_rdy", DW'(rdy), DW'(4'hF));
    repeat (6) drive(4'b0000, 1'b1);
    chk("midrst_no_stale", DW'(crdy), '0);
    stim = tbl[1].w;
    drive(4'hF, 1'b0);
    repeat (2) tick();
    chk("midrst_after_vec", rdata, tbl[1].exp);
    drain("midrst_drain");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rand_stim();
      drive(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
